param_nibble_core: RTL and testbench
====================================

# param_nibble_core

Parametrised multicycle accumulator core and successor to the fixed 8-bit nibble processor. It fetches fixed-format instructions from an external synchronous program memory and executes them in a four-state control FSM. Execution uses an internal data RAM, a result register and zero/carry flags. New over the previous generation: width/depth parameters, explicit STORE, unconditional and zero-conditional jumps, HALT, a `run` gate and status flags.

## Interface
- DATA_W, 8, datapath/result width; X and Y immediates are DATA_W each
- ADDR_W, 5, data RAM address width; depth 2^ADDR_W words of DATA_W
- PC_W, 5, program counter width; must be ≤ DATA_W
- INSTR_W (localparam) = 3+ADDR_W+2*DATA_W; fields MSB→LSB: op[2:0], addr, x, y
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- run  in  1  1 = allow next instruction fetch; sampled only in FETCH
- imem_en  out  1  program memory read strobe
- imem_addr  out  PC_W  program memory address (= pc)
- imem_data  in  INSTR_W  instruction word, valid the cycle after imem_en
- r  out  DATA_W  result register
- pc  out  PC_W  program counter
- zf  out  1  zero flag
- cf  out  1  carry / not-borrow flag
- halted  out  1  1 while in HALT

## Operation
- States: FETCH, DECODE, EXECUTE, WRITE, HALT. Reset → FETCH; pc=0, r=0, ir=0, zf=0, cf=0, halted=0, imem_en=0. Data RAM contents are not cleared.
- FETCH: imem_addr=pc, imem_en=run. run=1 → DECODE; run=0 → stay in FETCH, nothing changes.
- DECODE: ir ← imem_data → EXECUTE.
- EXECUTE: RAM read issued at ir.addr (sync, data next cycle). Op STORE writes MEM[ir.addr] ← r in this cycle. → WRITE.
- WRITE: operation per op, pc update → FETCH (HALT for op 7).
- Ops (M = RAM read data):
  - 0 ADD: r←Y+X
  - 1 LDADD: r←M+X
  - 2 SUB: r←Y−X
  - 3 LDSUB: r←M−X
  - 4 STORE: no r/flag change
  - 5 JMP: pc←Y[PC_W-1:0]
  - 6 JZ: pc←Y[PC_W-1:0] if zf=1, else pc+1
  - 7 HALT: halted←1
- Arithmetic: subtraction is A+~X+1. Computed at DATA_W+1 bits; r gets the low DATA_W, cf gets the bit DATA_W (SUB: cf=1 means no borrow). zf←(r_new==0). Flags change only on ops 0–3.
- pc ← pc+1 mod 2^PC_W for ops 0–4 and untaken JZ; wraps 2^PC_W−1 → 0. HALT leaves pc at the HALT address.
- HALT: absorbing, imem_en=0, only reset exits; run ignored.
- JZ tests zf as it stands before WRITE (flags from the previous ALU op).

## Timing
- Each instruction takes exactly 4 cycles once run=1 at FETCH; r/flags/pc visible the cycle after WRITE.
- run=0 in FETCH stalls indefinitely; run is ignored in other states (an instruction in flight always completes).
- Program memory latency is 1 cycle, fixed; no handshake beyond imem_en.
- STORE followed immediately by LDADD of the same addr returns the stored value (write at EXECUTE n, read at EXECUTE n+1).
- Reset asserted mid-instruction: all registers return to their reset values immediately (async); any in-progress RAM write in that cycle is suppressed; the FSM restarts at FETCH with pc=0 after release.

## Test plan
- Reset, run=1, program [ADD x=3 y=5; HALT] → r=0x08, zf=0, cf=0 at cycle 4; halted=1, pc=1 after cycle 8; imem_en stays 0 thereafter.
- [SUB x=5 y=5; JZ y=4; ADD x=1 y=1; HALT; ADD x=2 y=7; HALT] → r=0x00, zf=1, cf=1; jump taken; final r=0x09, pc=5.
- [ADD x=0xFF y=0x02; STORE addr=3; LDSUB addr=3 x=0x02; HALT] → r=0x01, cf=1; r=0xFF, cf=0 (borrow).
- Wrap: PC_W=5, JMP to 31 holding an ADD, then pc=0 → fetch address sequence 31, 0.
- run held 0 for 10 cycles after reset → imem_en=0, pc=0; run=1 → first fetch next edge.
- reset pulsed low during EXECUTE of STORE → outputs 0 at once, RAM word unchanged, restart fetch at 0.

Source files
------------

// File: rtl/param_nibble_core_if.sv
// Program-memory port of the nibble core: read strobe, address and returned instruction word.
// Latency: the slave returns imem_data exactly one cycle after a cycle with imem_en high.
// Backpressure: none; the slave must always answer, the core throttles itself through its run gate.
interface param_nibble_core_if #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 24
);
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;

  // Core side: drives the fetch strobe/address, consumes the instruction word.
  modport master (
    output imem_en,
    output imem_addr,
    input  imem_data
  );

  // Memory side: sees the fetch request, returns the instruction word.
  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_data
  );
endinterface

// File: rtl/param_nibble_core.sv
// Multicycle accumulator core: FETCH/DECODE/EXECUTE/WRITE over external program memory, internal data RAM.
// Latency: 4 cycles per instruction once run_i is seen high in FETCH; results visible after the WRITE edge.
// Backpressure: run_i low in FETCH stalls indefinitely; an instruction already fetched always completes.
module param_nibble_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 run_i,
  param_nibble_core_if.master  imem,
  output logic [DATA_W-1:0]    r_o,
  output logic [PC_W-1:0]      pc_o,
  output logic                 zf_o,
  output logic                 cf_o,
  output logic                 halted_o
);

  localparam int INSTR_W = 3 + ADDR_W + 2 * DATA_W;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_LDADD = 3'd1,
    OP_SUB   = 3'd2,
    OP_LDSUB = 3'd3,
    OP_STORE = 3'd4,
    OP_JMP   = 3'd5,
    OP_JZ    = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  state_e               state_q;
  logic [INSTR_W-1:0]   ir_q;
  logic [DATA_W-1:0]    r_q;
  logic [PC_W-1:0]      pc_q;
  logic                 zf_q;
  logic                 cf_q;
  logic                 halted_q;

  // Data RAM: no reset, contents survive a core reset.
  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [DATA_W-1:0]    rdata_q;

  // Instruction fields, MSB to LSB: op, addr, x, y.
  op_e                  op_w;
  logic [ADDR_W-1:0]    addr_w;
  logic [DATA_W-1:0]    x_w;
  logic [DATA_W-1:0]    y_w;

  // ALU and sequencing next values.
  logic                 is_load_d;
  logic                 is_sub_d;
  logic [DATA_W-1:0]    opa_d;
  logic [DATA_W-1:0]    opb_d;
  logic [DATA_W:0]      sum_d;
  logic [DATA_W-1:0]    res_d;
  logic                 carry_d;
  logic                 zero_d;
  logic [PC_W-1:0]      pc_inc_d;
  logic [PC_W-1:0]      jmp_tgt_d;

  assign op_w   = op_e'(ir_q[INSTR_W-1 -: 3]);
  assign addr_w = ir_q[2*DATA_W +: ADDR_W];
  assign x_w    = ir_q[DATA_W +: DATA_W];
  assign y_w    = ir_q[0 +: DATA_W];

  // Fetch strobe follows run only while waiting in FETCH; forced low while reset is held.
  assign imem.imem_en   = rst_ni && (state_q == S_FETCH) && run_i;
  assign imem.imem_addr = pc_q;

  assign r_o      = r_q;
  assign pc_o     = pc_q;
  assign zf_o     = zf_q;
  assign cf_o     = cf_q;
  assign halted_o = halted_q;

  // Shared adder: subtraction is A + ~X + 1, carry out doubles as not-borrow.
  always_comb begin
    is_load_d = (op_w == OP_LDADD) || (op_w == OP_LDSUB);
    is_sub_d  = (op_w == OP_SUB)   || (op_w == OP_LDSUB);
    opa_d     = is_load_d ? rdata_q : y_w;
    opb_d     = is_sub_d ? ~x_w : x_w;
    sum_d     = {1'b0, opa_d} + {1'b0, opb_d} + (DATA_W+1)'(is_sub_d);
    res_d     = sum_d[DATA_W-1:0];
    carry_d   = sum_d[DATA_W];
    zero_d    = (res_d == '0);
    pc_inc_d  = pc_q + PC_W'(1);
    jmp_tgt_d = y_w[PC_W-1:0];
  end

  // Data RAM port: read issued in EXECUTE (data used in WRITE); STORE writes r in the same cycle.
  // A reset forces state_q to FETCH asynchronously, which also suppresses any pending write.
  always_ff @(posedge clk_i) begin
    if (state_q == S_EXECUTE) begin
      if (op_w == OP_STORE) begin
        mem_q[addr_w] <= r_q;
      end
      rdata_q <= mem_q[addr_w];
    end
  end

  // Control FSM with all architectural state registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      r_q      <= '0;
      pc_q     <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (run_i) begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          ir_q    <= imem.imem_data;
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          state_q <= S_FETCH;
          case (op_w)
            OP_ADD, OP_LDADD, OP_SUB, OP_LDSUB: begin
              r_q  <= res_d;
              cf_q <= carry_d;
              zf_q <= zero_d;
              pc_q <= pc_inc_d;
            end
            OP_STORE: begin
              pc_q <= pc_inc_d;
            end
            OP_JMP: begin
              pc_q <= jmp_tgt_d;
            end
            OP_JZ: begin
              // Tests the flag left by the previous ALU op.
              pc_q <= zf_q ? jmp_tgt_d : pc_inc_d;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: begin
              pc_q <= pc_inc_d;
            end
          endcase
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_nibble_core.sv
// Self-checking bench for param_nibble_core: instruction-level reference model plus directed literal checks.
// Latency: model retires each instruction on the 4th edge after a fetch with run high.
// Backpressure: run is randomised in the random section to exercise FETCH stalls.
module tb_param_nibble_core;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int PW = 5;
  localparam int IW = 3 + AW + 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [DW-1:0] r;
  logic [PW-1:0] pc;
  logic          zf;
  logic          cf;
  logic          halted;

  param_nibble_core_if #(.PC_W(PW), .INSTR_W(IW)) bus ();

  param_nibble_core #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .run_i    (run),
    .imem     (bus.master),
    .r_o      (r),
    .pc_o     (pc),
    .zf_o     (zf),
    .cf_o     (cf),
    .halted_o (halted)
  );

  always #5 clk = ~clk;

  // Program memory: one-cycle synchronous read.
  logic [IW-1:0] prog [32];
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_data <= prog[bus.imem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [IW-1:0] ins(input int op, input int a, input int x, input int y);
    return {3'(op), 5'(a), 8'(x), 8'(y)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = ins(7, 0, 0, 0);
  endtask

  // ---------------- reference model (instruction level) ----------------
  int m_r = 0, m_pc = 0, m_zf = 0, m_cf = 0, m_halt = 0, m_phase = 0;
  logic [IW-1:0] m_cur = '0;
  int m_ram [32];

  task automatic model_step();
    int op, a, x, y, av, sum;
    if (!rst_n) begin
      m_r = 0; m_pc = 0; m_zf = 0; m_cf = 0; m_halt = 0; m_phase = 0;
      return;
    end
    if (m_halt != 0) return;
    op = int'(m_cur[23:21]);
    a  = int'(m_cur[20:16]);
    x  = int'(m_cur[15:8]);
    y  = int'(m_cur[7:0]);
    case (m_phase)
      0: if (run) begin m_cur = prog[m_pc]; m_phase = 1; end
      1: m_phase = 2;
      2: begin
        if (op == 4) m_ram[a] = m_r;
        m_phase = 3;
      end
      default: begin
        av = (op == 1 || op == 3) ? m_ram[a] : y;
        case (op)
          0, 1: begin
            sum  = av + x;
            m_cf = (sum > 255) ? 1 : 0;
            m_r  = sum % 256;
            m_zf = (m_r == 0) ? 1 : 0;
            m_pc = (m_pc + 1) % 32;
          end
          2, 3: begin
            m_cf = (av >= x) ? 1 : 0;
            m_r  = (av - x + 256) % 256;
            m_zf = (m_r == 0) ? 1 : 0;
            m_pc = (m_pc + 1) % 32;
          end
          4: m_pc = (m_pc + 1) % 32;
          5: m_pc = y % 32;
          6: m_pc = (m_zf != 0) ? (y % 32) : ((m_pc + 1) % 32);
          default: m_halt = 1;
        endcase
        m_phase = 0;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Compare DUT against model every cycle, mid low phase.
  initial forever begin
    int exp_en;
    @(negedge clk);
    #2;
    exp_en = (rst_n && m_halt == 0 && m_phase == 0 && run) ? 1 : 0;
    chk("r",       32'(r),           32'(m_r));
    chk("pc",      32'(pc),          32'(m_pc));
    chk("zf",      32'(zf),          32'(m_zf));
    chk("cf",      32'(cf),          32'(m_cf));
    chk("halted",  32'(halted),      32'(m_halt));
    chk("imem_en", 32'(bus.imem_en), 32'(exp_en));
    if (exp_en != 0) chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    clear_prog();
  endtask

  task automatic start_prog(input logic run_v);
    run = run_v;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int maxc);
    for (int i = 0; i < maxc && !halted; i++) @(negedge clk);
    #1;
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  logic [PW-1:0] fq [$];

  initial begin
    int rv, op, x, y, a;
    for (int i = 0; i < 32; i++) m_ram[i] = 0;
    clear_prog();
    tick(2);
    #1;
    chk("lit_reset_r",  32'(r), 32'd0);
    chk("lit_reset_en", 32'(bus.imem_en), 32'd0);

    // ADD then HALT
    hold_reset();
    prog[0] = ins(0, 0, 3, 5);
    prog[1] = ins(7, 0, 0, 0);
    start_prog(1'b1);
    tick(4); #1;
    chk("t1_r", 32'(r), 32'h08);
    chk("t1_zf", 32'(zf), 32'd0);
    chk("t1_cf", 32'(cf), 32'd0);
    chk("t1_halted_early", 32'(halted), 32'd0);
    tick(4); #1;
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_pc", 32'(pc), 32'd1);
    tick(5); #1;
    chk("t1_en_halt", 32'(bus.imem_en), 32'd0);

    // SUB to zero, taken JZ
    hold_reset();
    prog[0] = ins(2, 0, 5, 5);
    prog[1] = ins(6, 0, 0, 4);
    prog[2] = ins(0, 0, 1, 1);
    prog[3] = ins(7, 0, 0, 0);
    prog[4] = ins(0, 0, 2, 7);
    prog[5] = ins(7, 0, 0, 0);
    start_prog(1'b1);
    tick(4); #1;
    chk("t2_r0", 32'(r), 32'h00);
    chk("t2_zf", 32'(zf), 32'd1);
    chk("t2_cf", 32'(cf), 32'd1);
    tick(4); #1;
    chk("t2_jz_pc", 32'(pc), 32'd4);
    wait_halt(40);
    chk("t2_r", 32'(r), 32'h09);
    chk("t2_pc", 32'(pc), 32'd5);

    // carry, STORE, LDSUB with borrow
    hold_reset();
    prog[0] = ins(0, 0, 8'hFF, 8'h02);
    prog[1] = ins(4, 3, 0, 0);
    prog[2] = ins(3, 3, 8'h02, 0);
    prog[3] = ins(7, 0, 0, 0);
    start_prog(1'b1);
    tick(4); #1;
    chk("t3_r1", 32'(r), 32'h01);
    chk("t3_cf1", 32'(cf), 32'd1);
    wait_halt(40);
    chk("t3_r2", 32'(r), 32'hFF);
    chk("t3_cf2", 32'(cf), 32'd0);
    chk("t3_zf2", 32'(zf), 32'd0);

    // pc wrap 31 -> 0
    hold_reset();
    prog[0]  = ins(5, 0, 0, 31);
    prog[31] = ins(0, 0, 1, 1);
    fq.delete();
    start_prog(1'b1);
    repeat (16) begin
      #1;
      if (bus.imem_en) fq.push_back(bus.imem_addr);
      @(negedge clk);
    end
    chk("t4_fetch_cnt", 32'(fq.size()), 32'd4);
    if (fq.size() >= 4) begin
      chk("t4_fa0", 32'(fq[0]), 32'd0);
      chk("t4_fa1", 32'(fq[1]), 32'd31);
      chk("t4_fa2", 32'(fq[2]), 32'd0);
      chk("t4_fa3", 32'(fq[3]), 32'd31);
    end

    // run held low after reset
    hold_reset();
    prog[0] = ins(0, 0, 4, 4);
    prog[1] = ins(7, 0, 0, 0);
    start_prog(1'b0);
    tick(10); #1;
    chk("t5_en_stall", 32'(bus.imem_en), 32'd0);
    chk("t5_pc_stall", 32'(pc), 32'd0);
    @(negedge clk);
    run = 1'b1;
    #1;
    chk("t5_en_go", 32'(bus.imem_en), 32'd1);
    chk("t5_addr_go", 32'(bus.imem_addr), 32'd0);
    tick(4); #1;
    chk("t5_r", 32'(r), 32'h08);

    // reset during EXECUTE of a STORE
    hold_reset();
    prog[0] = ins(0, 0, 8'h11, 0);
    prog[1] = ins(4, 7, 0, 0);
    prog[2] = ins(0, 0, 8'h22, 0);
    prog[3] = ins(4, 7, 0, 0);
    prog[4] = ins(7, 0, 0, 0);
    start_prog(1'b1);
    tick(14); #1;
    chk("t6_r_before", 32'(r), 32'h22);
    rst_n = 1'b0;
    #1;
    chk("t6_r_rst", 32'(r), 32'd0);
    chk("t6_pc_rst", 32'(pc), 32'd0);
    chk("t6_en_rst", 32'(bus.imem_en), 32'd0);
    clear_prog();
    prog[0] = ins(1, 7, 0, 0);
    tick(2);
    start_prog(1'b1);
    wait_halt(40);
    chk("t6_ram_kept", 32'(r), 32'h11);

    // fill RAM words 0..15 with known values for random loads
    hold_reset();
    for (int i = 0; i < 16; i++) begin
      prog[2*i]   = ins(0, 0, $urandom_range(0, 255), 0);
      prog[2*i+1] = ins(4, i, 0, 0);
    end
    start_prog(1'b1);
    tick(140);

    // randomized programs with random run stalls
    for (int p = 0; p < 10; p++) begin
      hold_reset();
      for (int i = 0; i < 32; i++) begin
        rv = $urandom_range(0, 15);
        x  = $urandom_range(0, 255);
        y  = ($urandom_range(0, 3) == 0) ? x : $urandom_range(0, 255);
        a  = $urandom_range(0, 31);
        if (rv <= 2)       op = 0;
        else if (rv <= 4)  begin op = 1; a = $urandom_range(0, 15); end
        else if (rv <= 7)  op = 2;
        else if (rv <= 9)  begin op = 3; a = $urandom_range(0, 15); end
        else if (rv <= 11) op = 4;
        else if (rv == 12) op = 5;
        else if (rv <= 14) op = 6;
        else               op = 7;
        prog[i] = ins(op, a, x, y);
      end
      start_prog(1'b1);
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        run = ($urandom_range(0, 9) < 8);
      end
    end

    hold_reset();
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
